// File: rtl/steer_pkg.sv
// Shared types and constants for the steering command controller.
package steer_pkg;

    localparam int Y_W = 10;
    localparam logic [Y_W-1:0] CENTER_DEF = 10'd512;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRACK    = 2'd1,
        ST_FAILSAFE = 2'd2
    } steer_state_t;

endpackage

// File: rtl/steer_cmd_ctrl_slew_limiter.sv
// Combinational slew limiter: moves y_cur toward target by at most SLEW_STEP.
module slew_limiter
    import steer_pkg::*;
#(
    parameter int SLEW_STEP = 8
) (
    input  logic [Y_W-1:0] target,
    input  logic [Y_W-1:0] y_cur,
    output logic [Y_W-1:0] y_next
);

    localparam logic [Y_W:0]   STEP_W = (Y_W + 1)'(SLEW_STEP);
    localparam logic [Y_W-1:0] STEP_Y = Y_W'(SLEW_STEP);

    logic signed [Y_W:0] diff_s;
    logic        [Y_W:0] mag_s;

    // Signed distance to the target, its magnitude, and the limited next value
    always_comb begin
        diff_s = $signed({1'b0, target}) - $signed({1'b0, y_cur});
        if (diff_s[Y_W]) begin
            mag_s = $unsigned(-diff_s);
        end else begin
            mag_s = $unsigned(diff_s);
        end
        if (mag_s <= STEP_W) begin
            y_next = target;
        end else if (diff_s[Y_W]) begin
            y_next = y_cur - STEP_Y;
        end else begin
            y_next = y_cur + STEP_Y;
        end
    end

endmodule

// File: rtl/steer_cmd_ctrl.sv
// Steering command controller: SPI/test arbitration, link-loss failsafe and
// frame-aligned slew-limited release of the steering command.
module steer_cmd_ctrl
    import steer_pkg::*;
#(
    parameter logic [Y_W-1:0] CENTER         = CENTER_DEF,
    parameter int             SLEW_STEP      = 8,
    parameter int             TIMEOUT_FRAMES = 50
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           frame_start,
    input  logic [Y_W-1:0] spi_y,
    input  logic           spi_valid,
    input  logic           test_req,
    input  logic [Y_W-1:0] test_y,
    output logic [Y_W-1:0] y_cmd,
    output logic           y_cmd_upd,
    output logic           link_lost,
    output logic [1:0]     state
);

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT_FRAMES);

    steer_state_t   state_r, state_next_s;
    logic [7:0]     miss_r, miss_next_s;
    logic [8:0]     miss_inc_s;
    logic           link_lost_r;
    logic [Y_W-1:0] tgt_spi_r;
    logic           fresh_r;
    logic           test_req_r;
    logic [Y_W-1:0] test_y_r;
    logic [Y_W-1:0] target_s;
    logic [Y_W-1:0] y_next_s;
    logic [Y_W-1:0] y_cmd_r;
    logic           y_cmd_upd_r;

    // State, miss counter and link-lost flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            miss_r      <= 8'd0;
            link_lost_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            miss_r      <= miss_next_s;
            link_lost_r <= (state_next_s == ST_FAILSAFE);
        end
    end

    // Next-state and miss-count logic; a sample arriving on the frame edge
    // still counts as fresh for the frame that is ending
    always_comb begin
        state_next_s = state_r;
        miss_next_s  = miss_r;
        miss_inc_s   = {1'b0, miss_r} + 9'd1;
        if (!enable) begin
            state_next_s = ST_IDLE;
            miss_next_s  = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (spi_valid) begin
                        state_next_s = ST_TRACK;
                        miss_next_s  = 8'd0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_TRACK: begin
                    if (frame_start) begin
                        if (fresh_r || spi_valid) begin
                            miss_next_s = 8'd0;
                        end else if (miss_inc_s >= TIMEOUT_W) begin
                            miss_next_s  = miss_inc_s[7:0];
                            state_next_s = ST_FAILSAFE;
                        end else begin
                            miss_next_s = miss_inc_s[7:0];
                        end
                    end else begin
                        miss_next_s = miss_r;
                    end
                end
                ST_FAILSAFE: begin
                    if (spi_valid) begin
                        state_next_s = ST_TRACK;
                        miss_next_s  = 8'd0;
                    end else begin
                        state_next_s = ST_FAILSAFE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    miss_next_s  = 8'd0;
                end
            endcase
        end
    end

    // Sample latch, freshness flag and registered copy of the override inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_spi_r  <= CENTER;
            fresh_r    <= 1'b0;
            test_req_r <= 1'b0;
            test_y_r   <= CENTER;
        end else begin
            if (spi_valid) begin
                tgt_spi_r <= spi_y;
            end
            if (frame_start) begin
                fresh_r <= 1'b0;
            end else if (spi_valid) begin
                fresh_r <= 1'b1;
            end
            test_req_r <= test_req;
            test_y_r   <= test_y;
        end
    end

    // Target selection from registered state and sources
    always_comb begin
        target_s = CENTER;
        case (state_r)
            ST_IDLE:     target_s = CENTER;
            ST_TRACK:    target_s = test_req_r ? test_y_r : tgt_spi_r;
            ST_FAILSAFE: target_s = test_req_r ? test_y_r : CENTER;
            default:     target_s = CENTER;
        endcase
    end

    slew_limiter #(
        .SLEW_STEP(SLEW_STEP)
    ) u_slew (
        .target(target_s),
        .y_cur (y_cmd_r),
        .y_next(y_next_s)
    );

    // Release the slewed command only on PWM frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            y_cmd_r     <= CENTER;
            y_cmd_upd_r <= 1'b0;
        end else begin
            y_cmd_upd_r <= frame_start;
            if (frame_start) begin
                y_cmd_r <= y_next_s;
            end
        end
    end

    assign y_cmd     = y_cmd_r;
    assign y_cmd_upd = y_cmd_upd_r;
    assign link_lost = link_lost_r;
    assign state     = state_r;

endmodule

// File: tb/tb_steer_cmd_ctrl.sv
// Self-checking bench for steer_cmd_ctrl against a behavioural model.
module tb_steer_cmd_ctrl;

    localparam int STEP = 8;
    localparam int TO   = 50;
    localparam int CTR  = 512;

    logic       clk = 1'b0;
    logic       rst, enable, frame_start, spi_valid, test_req;
    logic [9:0] spi_y, test_y, y_cmd;
    logic       y_cmd_upd, link_lost;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // behavioural model: st 0=idle 1=track 2=failsafe
    int m_y, m_upd, m_st, m_miss, m_fresh, m_tgt, m_treq, m_ty;

    steer_cmd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_start(frame_start),
        .spi_y      (spi_y),
        .spi_valid  (spi_valid),
        .test_req   (test_req),
        .test_y     (test_y),
        .y_cmd      (y_cmd),
        .y_cmd_upd  (y_cmd_upd),
        .link_lost  (link_lost),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int slew(input int y, input int t);
        int d;
        d = t - y;
        if (d <= STEP && d >= -STEP) return t;
        else if (d > 0) return y + STEP;
        else return y - STEP;
    endfunction

    task automatic model_reset();
        m_y = CTR; m_upd = 0; m_st = 0; m_miss = 0;
        m_fresh = 0; m_tgt = CTR; m_treq = 0; m_ty = CTR;
    endtask

    task automatic model_step();
        int tgt_now;
        int st;
        if (rst) begin
            model_reset();
        end else begin
            st = m_st;
            if (st == 0)   tgt_now = CTR;
            else if (m_treq != 0) tgt_now = m_ty;
            else if (st == 1) tgt_now = m_tgt;
            else tgt_now = CTR;
            if (frame_start) begin
                m_y = slew(m_y, tgt_now);
                m_upd = 1;
            end else begin
                m_upd = 0;
            end
            if (!enable) begin
                m_st = 0; m_miss = 0;
            end else if (st == 0) begin
                if (spi_valid) begin m_st = 1; m_miss = 0; end
            end else if (st == 1) begin
                if (frame_start) begin
                    if (m_fresh != 0 || spi_valid) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss >= TO) m_st = 2;
                    end
                end
            end else begin
                if (spi_valid) begin m_st = 1; m_miss = 0; end
            end
            if (frame_start) m_fresh = 0;
            else if (spi_valid) m_fresh = 1;
            if (spi_valid) m_tgt = int'(spi_y);
            m_treq = int'(test_req);
            m_ty   = int'(test_y);
        end
    endtask

    task automatic cyc(input bit fs, input bit sv, input int sy);
        @(negedge clk);
        frame_start = fs;
        spi_valid   = sv;
        spi_y       = sy[9:0];
        @(posedge clk);
        model_step();
        #1;
        chk("y_cmd", y_cmd, m_y);
        chk("y_cmd_upd", y_cmd_upd, m_upd);
        chk("link_lost", link_lost, (m_st == 2) ? 1 : 0);
        chk("state", state, m_st);
    endtask

    // six-cycle PWM frame, frame_start in the last cycle
    task automatic frame(input bit sv, input int sy, input bit same);
        int pos;
        pos = $urandom_range(0, 4);
        for (int k = 0; k < 6; k++)
            cyc(k == 5, sv && (same ? (k == 5) : (k == pos)), sy);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; test_req = 1'b0; test_y = 10'd0;
        frame_start = 1'b0; spi_valid = 1'b0; spi_y = 10'd0;
        model_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset_y", y_cmd, 512);
        chk("reset_state", state, 0);
        chk("reset_link", link_lost, 0);

        // enabled, no SPI: stays idle at center
        rst = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) frame(0, 0, 0);
        chk("idle_state", state, 0);
        chk("idle_y", y_cmd, 512);

        // ramp to 600 and hold
        for (int i = 0; i < 14; i++) frame(1, 600, 0);
        chk("ramp_600", y_cmd, 600);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // override priority, then release
        test_req = 1'b1; test_y = 10'd1000;
        for (int i = 0; i < 10; i++) frame(1, 100, 0);
        chk("test_ramp", y_cmd, 680);
        test_req = 1'b0;
        for (int i = 0; i < 10; i++) frame(1, 100, 0);
        chk("back_ramp", y_cmd, 600);

        // link loss after exactly TO silent frames
        for (int i = 0; i < TO - 1; i++) frame(0, 0, 0);
        chk("pre_timeout_link", link_lost, 0);
        chk("pre_timeout_state", state, 1);
        frame(0, 0, 0);
        chk("timeout_link", link_lost, 1);
        chk("timeout_state", state, 2);
        chk("timeout_y", y_cmd, 200);
        for (int i = 0; i < 40; i++) frame(0, 0, 0);
        chk("failsafe_center", y_cmd, 512);
        frame(1, int'($urandom_range(0, 1023)), 0);
        chk("recover_state", state, 1);

        // same-cycle sample and frame edge; top-of-range landing
        for (int i = 0; i < 70; i++) frame(1, 1020, 0);
        chk("reach_1020", y_cmd, 1020);
        for (int i = 0; i < 10; i++) frame(0, 0, 0);
        frame(1, 1023, 1);
        chk("same_cycle_hold", y_cmd, 1020);
        frame(0, 0, 0);
        chk("top_1023", y_cmd, 1023);
        for (int i = 0; i < TO - 2; i++) frame(0, 0, 0);
        chk("miss_cleared_state", state, 1);
        frame(0, 0, 0);
        chk("miss_cleared_timeout", state, 2);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            test_req = ($urandom_range(0, 2) == 0);
            test_y   = 10'($urandom_range(0, 1023));
            frame($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
                  $urandom_range(0, 4) == 0);
        end

        // reset mid-ramp
        rst = 1'b1; enable = 1'b1; test_req = 1'b0;
        cyc(0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) frame(1, 600, 0);
        chk("midramp_560", y_cmd, 560);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0);
        chk("rst_y", y_cmd, 512);
        chk("rst_state", state, 0);
        chk("rst_link", link_lost, 0);
        rst = 1'b0;
        frame(1, 600, 0);
        chk("post_rst_slew", y_cmd, 520);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
